// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin share of one registered multiplier between two requesters.
// Latches the winner's operands, waits LAT clocks, then returns mul_out with a done pulse.
module mul_arbiter #(
    parameter int N   = 16,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    output logic         ack0,
    output logic         done0,
    output logic [N-1:0] res0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         ack1,
    output logic         done1,
    output logic [N-1:0] res1,
    output logic [N-1:0] mul_a,
    output logic [N-1:0] mul_b,
    input  logic [N-1:0] mul_out,
    output logic         busy
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t       state, state_nx;
    logic [2:0]   cnt, cnt_nx;
    logic         last, last_nx;
    logic         win;
    logic         ack0_nx, ack1_nx, done0_nx, done1_nx, busy_nx;
    logic [N-1:0] res0_nx, res1_nx, mul_a_nx, mul_b_nx;

    // last is both the round-robin pointer and the owner of the op in flight
    assign win = req1 & (~req0 | ~last);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        mul_a_nx = mul_a;
        mul_b_nx = mul_b;
        res0_nx  = res0;
        res1_nx  = res1;
        busy_nx  = busy;
        ack0_nx  = 1'b0;
        ack1_nx  = 1'b0;
        done0_nx = 1'b0;
        done1_nx = 1'b0;
        if (state == IDLE) begin
            if (req0 | req1) begin
                state_nx = WAIT;
                cnt_nx   = 3'(LAT);
                last_nx  = win;
                mul_a_nx = win ? a1 : a0;
                mul_b_nx = win ? b1 : b0;
                ack0_nx  = ~win;
                ack1_nx  = win;
                busy_nx  = 1'b1;
            end
        end else if (cnt == 3'd0) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            done0_nx = ~last;
            done1_nx = last;
            res0_nx  = last ? res0 : mul_out;
            res1_nx  = last ? mul_out : res1;
        end else begin
            cnt_nx = cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            last  <= 1'b1;
            mul_a <= '0;
            mul_b <= '0;
            res0  <= '0;
            res1  <= '0;
            busy  <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            last  <= last_nx;
            mul_a <= mul_a_nx;
            mul_b <= mul_b_nx;
            res0  <= res0_nx;
            res1  <= res1_nx;
            busy  <= busy_nx;
            ack0  <= ack0_nx;
            ack1  <= ack1_nx;
            done0 <= done0_nx;
            done1 <= done1_nx;
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed vectors, multi-cycle sequences and a random run against a
// transaction-level timestamp model; includes a LAT-stage multiplier model.
module tb_mul_arbiter;
    localparam int N   = 16;
    localparam int LAT = 3;

    logic         clk, rst;
    logic         req0, req1, ack0, ack1, done0, done1, busy;
    logic [N-1:0] a0, b0, a1, b1, res0, res1, mul_a, mul_b, mul_out;
    logic [N-1:0] pipe [LAT];

    int tests = 0;
    int fails = 0;

    mul_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .ack0(ack0), .done0(done0), .res0(res0),
        .req1(req1), .a1(a1), .b1(b1), .ack1(ack1), .done1(done1), .res1(res1),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // external registered multiplier: LAT pipeline stages
    always @(posedge clk) begin
        pipe[0] <= mul_a * mul_b;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_out = pipe[LAT-1];

    typedef struct {
        bit           p;
        logic [N-1:0] a, b, exp;
        string        name;
    } vec_t;
    vec_t tbl [7];

    // transaction-level reference: op accepted at edge t completes at t+LAT+1
    int           t, m_done_at;
    bit           m_pend, m_last, m_port;
    logic [N-1:0] m_val, e_res0, e_res1, e_ma, e_mb;
    bit           e_ack0, e_ack1, e_done0, e_done1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_pend = 1'b0; m_last = 1'b1; t = 0;
        e_res0 = '0; e_res1 = '0; e_ma = '0; e_mb = '0;
    endtask

    task automatic model_edge();
        {e_ack0, e_ack1, e_done0, e_done1} = 4'b0;
        if (m_pend) begin
            if (t == m_done_at) begin
                m_pend = 1'b0;
                if (m_port) begin e_done1 = 1'b1; e_res1 = m_val; end
                else        begin e_done0 = 1'b1; e_res0 = m_val; end
            end
        end else if (req0 || req1) begin
            m_port = (req0 && req1) ? !m_last : req1;
            m_last = m_port;
            e_ma = m_port ? a1 : a0;
            e_mb = m_port ? b1 : b0;
            m_val = N'(e_ma * e_mb);
            e_ack0 = !m_port;
            e_ack1 = m_port;
            m_pend = 1'b1;
            m_done_at = t + LAT + 1;
        end
        t++;
    endtask

    task automatic single(input bit p, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp, input string name);
        if (p) begin req1 = 1'b1; a1 = a; b1 = b; end
        else   begin req0 = 1'b1; a0 = a; b0 = b; end
        for (int n = 1; n <= LAT + 3; n++) begin
            @(negedge clk);
            if (n == 1) begin req0 = 1'b0; req1 = 1'b0; end
            chk({name, "_hs"}, {ack0, ack1, done0, done1},
                {n == 1 && !p, n == 1 && p, n == LAT + 2 && !p, n == LAT + 2 && p});
        end
        chk({name, "_res"}, p ? res1 : res0, exp);
    endtask

    // port 0 first, port 1 queued behind it (raised together or during WAIT)
    task automatic two_ops(input bit late, input string name);
        for (int n = 1; n <= 2 * LAT + 5; n++) begin
            @(negedge clk);
            if (n == 1) begin req0 = 1'b0; if (late) req1 = 1'b1; end
            if (n == LAT + 3) req1 = 1'b0;
            chk({name, "_seq"}, {ack0, done0, ack1, done1},
                {n == 1, n == LAT + 2, n == LAT + 3, n == 2 * LAT + 4});
        end
    endtask

    initial begin
        tbl[0] = '{0, 258,   258,   1028,  "single"};
        tbl[1] = '{0, 32767, 2,     65534, "trunc"};
        tbl[2] = '{1, 128,   256,   32768, "pow2"};
        tbl[3] = '{0, 0,     123,   0,     "zero_a"};
        tbl[4] = '{1, 100,   0,     0,     "zero_b"};
        tbl[5] = '{1, 65535, 65535, 1,     "wrap"};
        tbl[6] = '{0, 300,   300,   24464, "mod"};
        clk = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        do_reset();
        chk("reset", {ack0, ack1, done0, done1, busy, res0, res1, mul_a, mul_b}, 0);
        for (int i = 0; i < 7; i++) single(tbl[i].p, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);

        do_reset();
        req0 = 1'b1; a0 = 2; b0 = 3; req1 = 1'b1; a1 = 5; b1 = 4;
        two_ops(1'b0, "tie");
        chk("tie_res0", res0, 6);
        chk("tie_res1", res1, 20);

        do_reset();
        req0 = 1'b1; a0 = 3; b0 = 3; req1 = 1'b1; a1 = 4; b1 = 4;
        for (int n = 1; n <= 6 * (LAT + 2); n++) begin
            int k, ph;
            @(negedge clk);
            k = (n - 1) / (LAT + 2);
            ph = (n - 1) % (LAT + 2);
            chk("fair", {ack0, ack1, done0, done1},
                {ph == 0 && k % 2 == 0, ph == 0 && k % 2 == 1,
                 ph == LAT + 1 && k % 2 == 0, ph == LAT + 1 && k % 2 == 1});
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("fair_res", {res0, res1}, {16'd9, 16'd16});

        req0 = 1'b1; a0 = 11; b0 = 11; a1 = 6; b1 = 7;
        two_ops(1'b1, "late");
        chk("late_res", {res0, res1}, {16'd121, 16'd42});

        req0 = 1'b1; a0 = 7; b0 = 9;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst", {ack0, ack1, done0, done1, busy, res0, res1, mul_a, mul_b}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < LAT + 3; n++) begin
            @(negedge clk);
            chk("midrst_nodone", {done0, done1, busy}, 0);
        end
        single(1'b1, 10, 10, 100, "after_rst");

        do_reset();
        for (int c = 0; c < 400; c++) begin
            model_edge();
            @(negedge clk);
            chk("rnd_hs", {ack0, ack1, done0, done1, busy},
                {e_ack0, e_ack1, e_done0, e_done1, m_pend});
            chk("rnd_res", {res0, res1}, {e_res0, e_res1});
            chk("rnd_mul", {mul_a, mul_b}, {e_ma, e_mb});
            if (ack0) req0 = 1'b0;
            else if (!req0 && $urandom_range(3) == 0) begin
                req0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom);
            end
            if (ack1) req1 = 1'b0;
            else if (!req1 && $urandom_range(3) == 0) begin
                req1 = 1'b1; a1 = 16'($urandom); b1 = 16'($urandom);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end
endmodule
